word_bus_arbiter: RTL and testbench

//   Shares one 16-bit word path (op + data) between two requesters, e.g. fetch unit and load/store unit.

---
 rtl/word_bus_arbiter_pkg.sv | 16 +
 rtl/word_bus_arbiter_arb_rr_pick.sv | 35 +++
 rtl/word_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_word_bus_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_bus_arbiter_pkg.sv
// Shared constants and types for the two-requester word bus arbiter.
// Source IDs double as the word/op mux select value.
package word_bus_arbiter_pkg;

  localparam int WORD_W = 16;
  localparam int OP_W   = 5;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/word_bus_arbiter_arb_rr_pick.sv
// Combinational round-robin pick between two requesters, with optional lock to one owner.
// When both requesters are eligible, the one that did not win last time is picked.
module arb_rr_pick
  import word_bus_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  input  logic i_lock,
  input  logic i_lock_owner,
  output logic o_gnt0,
  output logic o_gnt1,
  output logic o_winner
);

  logic w_elig0;
  logic w_elig1;

  // While locked, only the lock owner may be picked.
  assign w_elig0 = i_req0 & (~i_lock | (i_lock_owner == SRC0));
  assign w_elig1 = i_req1 & (~i_lock | (i_lock_owner == SRC1));

  always_comb begin
    o_winner = SRC0;
    if (w_elig0 && w_elig1) begin
      o_winner = ~i_last;
    end else if (w_elig1) begin
      o_winner = SRC1;
    end
  end

  assign o_gnt0 = w_elig0 & (o_winner == SRC0);
  assign o_gnt1 = w_elig1 & (o_winner == SRC1);

endmodule

// File: rtl/word_bus_arbiter.sv
// Two-requester round-robin arbiter feeding a single-entry registered output buffer.
// Define ARB_LOCK_EN to add i_lock0/i_lock1 and lock arbitration to one requester.
module word_bus_arbiter
  import word_bus_arbiter_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int OPW   = OP_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0,
  input  logic [OPW-1:0]   i_op0,
  input  logic [WIDTH-1:0] i_data0,
  output logic             o_gnt0,
  input  logic             i_req1,
  input  logic [OPW-1:0]   i_op1,
  input  logic [WIDTH-1:0] i_data1,
  output logic             o_gnt1,
  output logic             o_valid,
  output logic [OPW-1:0]   o_op,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sel,
  input  logic             i_ready
`ifdef ARB_LOCK_EN
  ,
  input  logic             i_lock0,
  input  logic             i_lock1
`endif
);

  arb_state_e       r_state;
  logic             r_last;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_data;
  logic             r_sel;

  logic             w_can_accept;
  logic             w_pick_gnt0;
  logic             w_pick_gnt1;
  logic             w_winner;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_any_gnt;
  logic [OPW-1:0]   w_op;
  logic [WIDTH-1:0] w_data;
  logic             w_lock_active;
  logic             w_lock_owner;

`ifdef ARB_LOCK_EN
  logic r_lock;
  logic r_lock_owner;
  logic w_lock_req;

  assign w_lock_req    = (w_winner == SRC1) ? i_lock1 : i_lock0;
  assign w_lock_active = r_lock;
  assign w_lock_owner  = r_lock_owner;

  // An accepted beat with its lock bit set claims the bus; the owner's next unlocked beat frees it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock       <= 1'b0;
      r_lock_owner <= SRC0;
    end else if (w_any_gnt) begin
      if (w_lock_req) begin
        r_lock       <= 1'b1;
        r_lock_owner <= w_winner;
      end else if (r_lock && (r_lock_owner == w_winner)) begin
        r_lock <= 1'b0;
      end
    end
  end
`else
  assign w_lock_active = 1'b0;
  assign w_lock_owner  = SRC0;
`endif

  arb_rr_pick u_pick (
    .i_req0       (i_req0),
    .i_req1       (i_req1),
    .i_last       (r_last),
    .i_lock       (w_lock_active),
    .i_lock_owner (w_lock_owner),
    .o_gnt0       (w_pick_gnt0),
    .o_gnt1       (w_pick_gnt1),
    .o_winner     (w_winner)
  );

  // Handshake: a beat moves when valid and ready are both high in the same cycle; a requester
  // holds its beat until granted, and the buffer holds its beat until the consumer takes it.
  assign w_can_accept = (r_state == ST_EMPTY) | i_ready;
  assign w_gnt0       = w_pick_gnt0 & w_can_accept & i_rst_n;
  assign w_gnt1       = w_pick_gnt1 & w_can_accept & i_rst_n;
  assign w_any_gnt    = w_gnt0 | w_gnt1;

  assign w_op   = (w_winner == SRC1) ? i_op1   : i_op0;
  assign w_data = (w_winner == SRC1) ? i_data1 : i_data0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_EMPTY;
      r_last  <= SRC1;
      r_op    <= '0;
      r_data  <= '0;
      r_sel   <= SRC0;
    end else if (w_any_gnt) begin
      r_state <= ST_FULL;
      r_last  <= w_winner;
      r_op    <= w_op;
      r_data  <= w_data;
      r_sel   <= w_winner;
    end else if ((r_state == ST_FULL) && i_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  assign o_gnt0  = w_gnt0;
  assign o_gnt1  = w_gnt1;
  assign o_valid = (r_state == ST_FULL);
  assign o_op    = r_op;
  assign o_data  = r_data;
  assign o_sel   = r_sel;

endmodule

// File: tb/tb_word_bus_arbiter.sv
// Directed scenarios plus a randomized run checked against a queue-based reference model.
// Build with ARB_LOCK_EN defined to also exercise the lock scenario.
module tb_word_bus_arbiter;

  localparam int W   = 16;
  localparam int OPW = 5;
  localparam int EW  = 1 + OPW + W;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic           i_clk;
  logic           i_rst_n;
  logic           i_req0;
  logic [OPW-1:0] i_op0;
  logic [W-1:0]   i_data0;
  logic           o_gnt0;
  logic           i_req1;
  logic [OPW-1:0] i_op1;
  logic [W-1:0]   i_data1;
  logic           o_gnt1;
  logic           o_valid;
  logic [OPW-1:0] o_op;
  logic [W-1:0]   o_data;
  logic           o_sel;
  logic           i_ready;
  logic           i_lock0;
  logic           i_lock1;

  int n_vec;
  int n_err;

  word_bus_arbiter #(.WIDTH(W), .OPW(OPW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req0  (i_req0),
    .i_op0   (i_op0),
    .i_data0 (i_data0),
    .o_gnt0  (o_gnt0),
    .i_req1  (i_req1),
    .i_op1   (i_op1),
    .i_data1 (i_data1),
    .o_gnt1  (o_gnt1),
    .o_valid (o_valid),
    .o_op    (o_op),
    .o_data  (o_data),
    .o_sel   (o_sel),
    .i_ready (i_ready)
`ifdef ARB_LOCK_EN
    ,
    .i_lock0 (i_lock0),
    .i_lock1 (i_lock1)
`endif
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_req0  = 1'b0;
    i_req1  = 1'b0;
    i_lock0 = 1'b0;
    i_lock1 = 1'b0;
    i_ready = 1'b1;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_req0 = 1'b1; i_op0 = 5'h07; i_data0 = 16'h1234;
    i_req1 = 1'b0; i_ready = 1'b1;
    @(negedge i_clk);
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_vec++; if (o_gnt0 !== 1'b0) begin n_err++; $display("FAIL reset_gnt0: got %b want 0", o_gnt0); end
    n_vec++; if (o_gnt1 !== 1'b0) begin n_err++; $display("FAIL reset_gnt1: got %b want 0", o_gnt1); end
    n_vec++; if (o_op !== 5'h00) begin n_err++; $display("FAIL reset_op: got %h want 00", o_op); end
    n_vec++; if (o_data !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h want 0000", o_data); end
    n_vec++; if (o_sel !== 1'b0) begin n_err++; $display("FAIL reset_sel: got %b want 0", o_sel); end
    tick();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    n_vec++; if (o_gnt0 !== 1'b1) begin n_err++; $display("FAIL first_gnt0: got %b want 1", o_gnt0); end
    tick();
    i_req0 = 1'b0;
    @(negedge i_clk);
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b want 1", o_valid); end
    n_vec++; if (o_data !== 16'h1234) begin n_err++; $display("FAIL first_data: got %h want 1234", o_data); end
    n_vec++; if (o_op !== 5'h07) begin n_err++; $display("FAIL first_op: got %h want 07", o_op); end
    tick();
    @(negedge i_clk);
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL first_drain: got %b want 0", o_valid); end
  endtask

  task automatic test_tie();
    logic         exp_sel;
    logic [W-1:0] exp_data;
    do_reset();
    i_req0 = 1'b1; i_op0 = 5'h01; i_data0 = 16'h1111;
    i_req1 = 1'b1; i_op1 = 5'h02; i_data1 = 16'h2222;
    i_ready = 1'b1;
    @(negedge i_clk);
    n_vec++; if (o_gnt0 !== 1'b1 || o_gnt1 !== 1'b0) begin
      n_err++; $display("FAIL tie_first_gnt: got %b%b want 10", o_gnt0, o_gnt1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge i_clk);
      exp_sel  = (i % 2) != 0;
      exp_data = exp_sel ? 16'h2222 : 16'h1111;
      n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL tie_valid[%0d]: got %b want 1", i, o_valid); end
      n_vec++; if (o_data !== exp_data) begin n_err++; $display("FAIL tie_data[%0d]: got %h want %h", i, o_data, exp_data); end
      n_vec++; if (o_sel !== exp_sel) begin n_err++; $display("FAIL tie_sel[%0d]: got %b want %b", i, o_sel, exp_sel); end
      if (i == 2) begin
        i_req0 = 1'b0;
        i_req1 = 1'b0;
        #1;
        n_vec++; if (o_gnt0 !== 1'b0 || o_gnt1 !== 1'b0) begin
          n_err++; $display("FAIL tie_withdraw_gnt: got %b%b want 00", o_gnt0, o_gnt1);
        end
      end else begin
        n_vec++; if (o_gnt0 !== exp_sel || o_gnt1 !== !exp_sel) begin
          n_err++; $display("FAIL tie_gnt[%0d]: got %b%b want %b%b", i, o_gnt0, o_gnt1, exp_sel, !exp_sel);
        end
      end
    end
    tick();
    @(negedge i_clk);
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL tie_drain: got %b want 0", o_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    i_ready = 1'b0;
    i_req0 = 1'b1; i_op0 = 5'h03; i_data0 = 16'hABCD;
    i_req1 = 1'b0;
    @(negedge i_clk);
    n_vec++; if (o_gnt0 !== 1'b1) begin n_err++; $display("FAIL bp_load_gnt0: got %b want 1", o_gnt0); end
    tick();
    i_op0 = 5'h01; i_data0 = 16'h0101;
    i_req1 = 1'b1; i_op1 = 5'h02; i_data1 = 16'h0202;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      n_vec++; if (o_valid !== 1'b1 || o_data !== 16'hABCD || o_op !== 5'h03 || o_sel !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%b op=%h d=%h s=%b want v=1 op=03 d=abcd s=0", i, o_valid, o_op, o_data, o_sel);
      end
      n_vec++; if (o_gnt0 !== 1'b0 || o_gnt1 !== 1'b0) begin
        n_err++; $display("FAIL bp_nogrant[%0d]: got %b%b want 00", i, o_gnt0, o_gnt1);
      end
      tick();
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    n_vec++; if (o_gnt1 !== 1'b1 || o_gnt0 !== 1'b0) begin
      n_err++; $display("FAIL bp_release_gnt: got %b%b want 01", o_gnt0, o_gnt1);
    end
    n_vec++; if (o_data !== 16'hABCD) begin n_err++; $display("FAIL bp_release_data: got %h want abcd", o_data); end
    tick();
    i_req1 = 1'b0;
    @(negedge i_clk);
    n_vec++; if (o_data !== 16'h0202 || o_sel !== 1'b1 || o_op !== 5'h02) begin
      n_err++; $display("FAIL bp_next_beat: got op=%h d=%h s=%b want op=02 d=0202 s=1", o_op, o_data, o_sel);
    end
    n_vec++; if (o_gnt0 !== 1'b1) begin n_err++; $display("FAIL bp_gnt0_after: got %b want 1", o_gnt0); end
    tick();
    i_req0 = 1'b0;
    @(negedge i_clk);
    n_vec++; if (o_data !== 16'h0101 || o_sel !== 1'b0) begin
      n_err++; $display("FAIL bp_last_beat: got d=%h s=%b want d=0101 s=0", o_data, o_sel);
    end
    tick();
    @(negedge i_clk);
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", o_valid); end
  endtask

  task automatic test_single_source();
    logic [W-1:0] exp_data;
    do_reset();
    i_ready = 1'b1;
    i_req0 = 1'b0;
    i_req1 = 1'b1; i_op1 = 5'h04; i_data1 = 16'h3000;
    @(negedge i_clk);
    n_vec++; if (o_gnt1 !== 1'b1 || o_gnt0 !== 1'b0) begin
      n_err++; $display("FAIL single_first_gnt: got %b%b want 01", o_gnt0, o_gnt1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) begin
        i_op1   = 5'(i + 5);
        i_data1 = 16'(16'h3001 + i);
      end else begin
        i_req1 = 1'b0;
      end
      @(negedge i_clk);
      exp_data = 16'(16'h3000 + i);
      n_vec++; if (o_valid !== 1'b1 || o_sel !== 1'b1 || o_data !== exp_data) begin
        n_err++; $display("FAIL single_beat[%0d]: got v=%b s=%b d=%h want v=1 s=1 d=%h", i, o_valid, o_sel, o_data, exp_data);
      end
      n_vec++; if (o_gnt1 !== (i < 2)) begin
        n_err++; $display("FAIL single_gnt[%0d]: got %b want %b", i, o_gnt1, (i < 2));
      end
    end
    tick();
    @(negedge i_clk);
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", o_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_ready = 1'b0;
    i_req0 = 1'b1; i_op0 = 5'h0A; i_data0 = 16'h5A5A;
    i_req1 = 1'b0;
    tick();
    i_req0 = 1'b0;
    @(negedge i_clk);
    n_vec++; if (o_valid !== 1'b1 || o_data !== 16'h5A5A) begin
      n_err++; $display("FAIL mid_loaded: got v=%b d=%h want v=1 d=5a5a", o_valid, o_data);
    end
    #1;
    i_rst_n = 1'b0;
    i_req0  = 1'b1;
    #1;
    n_vec++; if (o_valid !== 1'b0 || o_data !== 16'h0000) begin
      n_err++; $display("FAIL mid_async_clear: got v=%b d=%h want v=0 d=0000", o_valid, o_data);
    end
    n_vec++; if (o_gnt0 !== 1'b0) begin n_err++; $display("FAIL mid_no_grant: got %b want 0", o_gnt0); end
    tick();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    n_vec++; if (o_gnt0 !== 1'b1) begin n_err++; $display("FAIL mid_regrant: got %b want 1", o_gnt0); end
    tick();
    i_req0 = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    n_vec++; if (o_valid !== 1'b1 || o_data !== 16'h5A5A) begin
      n_err++; $display("FAIL mid_represent: got v=%b d=%h want v=1 d=5a5a", o_valid, o_data);
    end
    tick();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    i_ready = 1'b1;
    i_req1 = 1'b1; i_op1 = 5'h0B; i_data1 = 16'h2BBB; i_lock1 = 1'b0;
    i_req0 = 1'b1; i_op0 = 5'h10; i_data0 = 16'h1A00; i_lock0 = 1'b1;
    @(negedge i_clk);
    n_vec++; if (o_gnt0 !== 1'b1 || o_gnt1 !== 1'b0) begin n_err++; $display("FAIL lock_gnt_b0: got %b%b want 10", o_gnt0, o_gnt1); end
    tick();
    i_data0 = 16'h1A01; i_lock0 = 1'b1;
    @(negedge i_clk);
    n_vec++; if (o_gnt0 !== 1'b1 || o_gnt1 !== 1'b0) begin n_err++; $display("FAIL lock_gnt_b1: got %b%b want 10", o_gnt0, o_gnt1); end
    n_vec++; if (o_data !== 16'h1A00) begin n_err++; $display("FAIL lock_data_b0: got %h want 1a00", o_data); end
    tick();
    i_req0 = 1'b0;
    @(negedge i_clk);
    n_vec++; if (o_gnt1 !== 1'b0) begin n_err++; $display("FAIL lock_idle_gnt1_a: got %b want 0", o_gnt1); end
    n_vec++; if (o_data !== 16'h1A01) begin n_err++; $display("FAIL lock_data_b1: got %h want 1a01", o_data); end
    tick();
    @(negedge i_clk);
    n_vec++; if (o_gnt1 !== 1'b0 || o_valid !== 1'b0) begin
      n_err++; $display("FAIL lock_idle_b: got gnt1=%b v=%b want gnt1=0 v=0", o_gnt1, o_valid);
    end
    tick();
    i_req0 = 1'b1; i_data0 = 16'h1A02; i_lock0 = 1'b0;
    @(negedge i_clk);
    n_vec++; if (o_gnt0 !== 1'b1 || o_gnt1 !== 1'b0) begin n_err++; $display("FAIL lock_gnt_b2: got %b%b want 10", o_gnt0, o_gnt1); end
    tick();
    i_req0 = 1'b0;
    @(negedge i_clk);
    n_vec++; if (o_data !== 16'h1A02) begin n_err++; $display("FAIL lock_data_b2: got %h want 1a02", o_data); end
    n_vec++; if (o_gnt1 !== 1'b1) begin n_err++; $display("FAIL lock_unlocked_gnt1: got %b want 1", o_gnt1); end
    tick();
    i_req1 = 1'b0;
    @(negedge i_clk);
    n_vec++; if (o_data !== 16'h2BBB || o_sel !== 1'b1) begin
      n_err++; $display("FAIL lock_req1_beat: got d=%h s=%b want d=2bbb s=1", o_data, o_sel);
    end
    tick();
  endtask
`endif

  // Reference model: accepted beats go into exp_q; the consumer must see them in order.
  task automatic test_random();
    logic [EW-1:0]  exp_q[$];
    bit             req_b[2];
    logic [OPW-1:0] op_b[2];
    logic [W-1:0]   dat_b[2];
    bit             lk_b[2];
    bit             granted[2];
    bit             m_last, m_lock, m_owner;
    bit             exp_valid, can, e0, e1, win, g0, g1;
    logic [EW-1:0]  got;
    do_reset();
    m_last = 1'b1; m_lock = 1'b0; m_owner = 1'b0;
    for (int n = 0; n < 2; n++) begin
      req_b[n] = 1'b0; granted[n] = 1'b0; lk_b[n] = 1'b0;
      op_b[n] = '0; dat_b[n] = '0;
    end
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!req_b[n] || granted[n]) begin
          if ($urandom_range(0, 9) < 6) begin
            req_b[n] = 1'b1;
            op_b[n]  = OPW'($urandom);
            dat_b[n] = W'($urandom);
            lk_b[n]  = ($urandom_range(0, 3) == 0);
          end else begin
            req_b[n] = 1'b0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_b[n] = 1'b0;
        end
      end
      i_req0 = req_b[0]; i_op0 = op_b[0]; i_data0 = dat_b[0]; i_lock0 = lk_b[0];
      i_req1 = req_b[1]; i_op1 = op_b[1]; i_data1 = dat_b[1]; i_lock1 = lk_b[1];
      i_ready = ($urandom_range(0, 3) != 0);
      @(negedge i_clk);
      exp_valid = (exp_q.size() != 0);
      n_vec++; if (o_valid !== exp_valid) begin
        n_err++; $display("FAIL rand_valid[%0d]: got %b want %b", cyc, o_valid, exp_valid);
      end
      if (exp_valid) begin
        got = {o_sel, o_op, o_data};
        n_vec++; if (got !== exp_q[0]) begin
          n_err++; $display("FAIL rand_beat[%0d]: got %h want %h", cyc, got, exp_q[0]);
        end
      end
      can = !exp_valid || i_ready;
      e0  = req_b[0] && (!m_lock || m_owner == 1'b0);
      e1  = req_b[1] && (!m_lock || m_owner == 1'b1);
      if (e0 && e1) win = !m_last;
      else          win = e1;
      g0 = can && e0 && (win == 1'b0);
      g1 = can && e1 && (win == 1'b1);
      n_vec++; if (o_gnt0 !== g0 || o_gnt1 !== g1) begin
        n_err++; $display("FAIL rand_gnt[%0d]: got %b%b want %b%b", cyc, o_gnt0, o_gnt1, g0, g1);
      end
      if (exp_valid && i_ready) void'(exp_q.pop_front());
      if (g0 || g1) begin
        exp_q.push_back({win, op_b[int'(win)], dat_b[int'(win)]});
        m_last = win;
        if (LOCK_ON && lk_b[int'(win)]) begin
          m_lock  = 1'b1;
          m_owner = win;
        end else if (m_lock && m_owner == win) begin
          m_lock = 1'b0;
        end
      end
      granted[0] = g0;
      granted[1] = g1;
      tick();
    end
    i_req0 = 1'b0; i_req1 = 1'b0; i_ready = 1'b1;
    tick();
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    i_rst_n = 1'b0;
    i_req0  = 1'b0; i_op0 = '0; i_data0 = '0;
    i_req1  = 1'b0; i_op1 = '0; i_data1 = '0;
    i_ready = 1'b1;
    i_lock0 = 1'b0; i_lock1 = 1'b0;
    test_reset();
    test_tie();
    test_backpressure();
    test_single_source();
    test_reset_mid();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
